key_conditioner: RTL
====================

// Module: key_conditioner
// PURPOSE
//   Input-conditioning stage in front of the 8-bit shift-add multiplier datapath.
//   Synchronises raw active-low pushbuttons and slide switches, debounces each key,
//   and emits clean active-high levels plus one-cycle press/release pulses.
//   Captures the operand switches on a debounced Load press, so the multiplier sees stable S.
// PARAMETERS
//   N_KEYS           3   number of pushbuttons conditioned (bit 0 = Reset, 1 = Load, 2 = Run)
//   SW_WIDTH         8   slide-switch operand width
//   DEBOUNCE_CYCLES  50000  stable-sample count to accept a level change; legal range >= 2
//   LOAD_KEY         1   key index whose press captures SW into SW_held
// PORTS
//   Clk          in   1         system clock
//   Reset        in   1         synchronous, active-high reset
//   Key_n        in   N_KEYS    raw pushbuttons, active-low, asynchronous
//   SW           in   SW_WIDTH  raw slide switches, asynchronous
//   Key_level    out  N_KEYS    debounced key state, 1 = pressed
//   Key_press    out  N_KEYS    one-cycle pulse on accepted press
//   Key_release  out  N_KEYS    one-cycle pulse on accepted release
//   SW_sync      out  SW_WIDTH  two-flop-synchronised switches (not debounced)
//   SW_held      out  SW_WIDTH  SW_sync captured on Key_press[LOAD_KEY]
// BEHAVIOUR
// - Reset (sync): key sync flops -> 1 (released), SW sync flops -> 0, all FSMs -> K_UP,
//   counters -> 0; Key_level, Key_press, Key_release, SW_sync, SW_held -> 0.
// - Sync: two flops per bit (s1, s2); FSM and capture logic use s2 only.
// - Per-key FSM, counter cnt width $clog2(DEBOUNCE_CYCLES):
//   K_UP:      s2==0 -> K_CONF_DN, cnt<=0.
//   K_CONF_DN: s2==1 -> K_UP (glitch rejected, no pulse); s2==0 & cnt<DEBOUNCE_CYCLES-1 -> cnt++;
//              s2==0 & cnt==DEBOUNCE_CYCLES-1 -> K_DOWN, Key_press<=1 for one cycle.
//   K_DOWN:    s2==1 -> K_CONF_UP, cnt<=0.
//   K_CONF_UP: mirror of K_CONF_DN; on acceptance -> K_UP, Key_release<=1 for one cycle.
//   Key_level = 1 in K_DOWN and K_CONF_UP; 0 in K_UP and K_CONF_DN (registered).
// - Latency: key sampled low at edge 0 and held -> Key_press high after edge DEBOUNCE_CYCLES+2;
//   same latency for release. Pulses never exceed one cycle; a held key gives one press only.
// - Any bounce inside the confirm window restarts from K_UP/K_DOWN; counter never wraps.
// - Keys are independent: simultaneous presses produce pulses in the same cycle.
// - SW_held <= SW_sync on the edge after Key_press[LOAD_KEY] is high; otherwise holds.
//   SW changes without a Load press never alter SW_held.
// - Reset mid-debounce: pending transition discarded, no pulse emitted. A key still held
//   when Reset drops is re-detected: Key_press after DEBOUNCE_CYCLES+2 edges (sync reload).
// - All outputs registered; no combinational path from Key_n/SW to any output.
// STRUCTURE
//   Package key_pkg: typedef enum logic [1:0] {K_UP, K_CONF_DN, K_DOWN, K_CONF_UP}
//   key_state_t; localparams KEY_RESET=0, KEY_LOAD=1, KEY_RUN=2.
//   Sub-module key_debounce (sync pair + FSM + counter + pulse regs for one key),
//   instantiated N_KEYS times via generate; switch sync and SW_held capture live in top.
// TESTING (DEBOUNCE_CYCLES=4 for all)
//   1 Reset held 3 cycles, Key_n=3'b111, SW=8'hFF -> all outputs 0; SW_sync=8'hFF 2 cycles after release.
//   2 Key_n[2] low from edge 0 for 20 cycles -> Key_press[2] single pulse after edge 6,
//     Key_level[2]=1 from then; release -> Key_release[2] pulse 6 edges later, level 0.
//   3 Key_n[1] low 3 cycles then high -> no pulse; then toggle every 2 cycles x4, hold low
//     -> exactly one Key_press[1].
//   4 SW=8'hA5, press Load -> SW_held=8'hA5 after pulse; SW=8'h3C no press -> SW_held stays 8'hA5.
//   5 Key_n[2] low, Reset asserted at cnt==2 for 1 cycle, key held -> no pulse during
//     reset; Key_press[2] 6 edges after Reset deasserts.
//   6 Key_n[1] and Key_n[2] fall on same edge -> Key_press[1] and [2] high in same cycle,
//     SW_held updated once.

Source files
------------

// File: rtl/key_conditioner_pkg.sv
// Shared types and key indices for the pushbutton/switch conditioning stage.
package key_pkg;

    typedef enum logic [1:0] {K_UP, K_CONF_DN, K_DOWN, K_CONF_UP} key_state_t;

    localparam int unsigned KEY_RESET = 0;
    localparam int unsigned KEY_LOAD  = 1;
    localparam int unsigned KEY_RUN   = 2;

endpackage

// File: rtl/key_conditioner_if.sv
// Raw key/switch inputs and conditioned outputs of key_conditioner.
interface key_conditioner_if #(
    parameter int unsigned N_KEYS   = 3,
    parameter int unsigned SW_WIDTH = 8
);
    logic [N_KEYS-1:0]   Key_n;
    logic [SW_WIDTH-1:0] SW;
    logic [N_KEYS-1:0]   Key_level;
    logic [N_KEYS-1:0]   Key_press;
    logic [N_KEYS-1:0]   Key_release;
    logic [SW_WIDTH-1:0] SW_sync;
    logic [SW_WIDTH-1:0] SW_held;

    modport master (
        output Key_n, SW,
        input  Key_level, Key_press, Key_release, SW_sync, SW_held
    );

    modport slave (
        input  Key_n, SW,
        output Key_level, Key_press, Key_release, SW_sync, SW_held
    );
endinterface

// File: rtl/key_conditioner_debounce.sv
// One key: two-flop synchroniser, debounce FSM with confirm counter, registered level and pulses.
module key_debounce
    import key_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
    input  logic clk,
    input  logic reset,
    input  logic key_n,
    output logic level,
    output logic press_pulse,
    output logic release_pulse
);
    localparam int unsigned CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          s1, s2;
    key_state_t    state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic          level_nxt, press_nxt, release_nxt;

    always_ff @(posedge clk) begin
        if (reset) begin
            s1            <= 1'b1;
            s2            <= 1'b1;
            state         <= K_UP;
            cnt           <= '0;
            level         <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
        end else begin
            s1            <= key_n;
            s2            <= s1;
            state         <= state_nxt;
            cnt           <= cnt_nxt;
            level         <= level_nxt;
            press_pulse   <= press_nxt;
            release_pulse <= release_nxt;
        end
    end

    // A bounce during confirmation falls back to the stable state rather than restarting the count.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            K_UP: begin
                if (!s2) begin
                    state_nxt = K_CONF_DN;
                    cnt_nxt   = '0;
                end
            end
            K_CONF_DN: begin
                if (s2)                   state_nxt = K_UP;
                else if (cnt == CNT_LAST) state_nxt = K_DOWN;
                else                      cnt_nxt   = cnt + CW'(1);
            end
            K_DOWN: begin
                if (s2) begin
                    state_nxt = K_CONF_UP;
                    cnt_nxt   = '0;
                end
            end
            K_CONF_UP: begin
                if (!s2)                  state_nxt = K_DOWN;
                else if (cnt == CNT_LAST) state_nxt = K_UP;
                else                      cnt_nxt   = cnt + CW'(1);
            end
            default: state_nxt = K_UP;
        endcase
    end

    always_comb begin
        level_nxt   = (state_nxt == K_DOWN) || (state_nxt == K_CONF_UP);
        press_nxt   = (state == K_CONF_DN) && (state_nxt == K_DOWN);
        release_nxt = (state == K_CONF_UP) && (state_nxt == K_UP);
    end
endmodule

// File: rtl/key_conditioner.sv
// Debounces N_KEYS pushbuttons, synchronises the operand switches and latches them on a Load press.
module key_conditioner
    import key_pkg::*;
#(
    parameter int unsigned N_KEYS          = 3,
    parameter int unsigned SW_WIDTH        = 8,
    parameter int unsigned DEBOUNCE_CYCLES = 50000,
    parameter int unsigned LOAD_KEY        = KEY_LOAD
) (
    input logic              Clk,
    input logic              Reset,
    key_conditioner_if.slave bus
);
    logic [N_KEYS-1:0]   level, press, release_p;
    logic [SW_WIDTH-1:0] sw_s1, sw_s2, held;

    for (genvar k = 0; k < N_KEYS; k++) begin : g_key
        key_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_key (
            .clk          (Clk),
            .reset        (Reset),
            .key_n        (bus.Key_n[k]),
            .level        (level[k]),
            .press_pulse  (press[k]),
            .release_pulse(release_p[k])
        );
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            sw_s1 <= '0;
            sw_s2 <= '0;
            held  <= '0;
        end else begin
            sw_s1 <= bus.SW;
            sw_s2 <= sw_s1;
            if (press[LOAD_KEY]) held <= sw_s2;
        end
    end

    assign bus.Key_level   = level;
    assign bus.Key_press   = press;
    assign bus.Key_release = release_p;
    assign bus.SW_sync     = sw_s2;
    assign bus.SW_held     = held;
endmodule
